iq_snap_ctrl: RTL

- Snapshot sequencer for the 4-channel I/Q product datapath.
- On a software start, clears the downstream covariance accumulator and admits exactly num_snap aligned I/Q beats from all eight channel streams into the product stage.
- Enables accumulation for exactly num_snap product beats, then reports done and holds until acknowledged.
- Sits between the ADC channel streams and the product stage and drives their ready lines and the accumulator controls.

---
 rtl/iq_snap_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/iq_snap_ctrl.sv
// Snapshot sequencer for the 4-channel I/Q product datapath: clears the accumulator,
// admits num_snap aligned beats, accumulates num_snap products. Watchdog: IQ_SNAP_CTRL_TIMEOUT_EN.
module iq_snap_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             ack,
  input  logic [CNT_W-1:0] num_snap,
  input  logic [7:0]       ch_valid,
  output logic [7:0]       ch_ready,
  input  logic             prod_valid,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] snap_cnt,
  output logic             align_err,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] nsnap_r, nsnap_nx;
  logic [CNT_W-1:0] in_cnt, in_cnt_nx;
  logic [CNT_W-1:0] snap_cnt_r, snap_cnt_nx;
  logic             align_r, align_nx;
  logic             tmo_r, tmo_nx;
  logic             busy_r;
  logic             all_valid, partial_valid, admit, acc_en_c, wd_fire;

  // Ready is a function of valid so that all eight streams move in the same cycle.
  always_comb begin
    all_valid     = &ch_valid;
    partial_valid = (|ch_valid) && !all_valid;
    admit         = (state == S_ACCUM) && all_valid && (in_cnt < nsnap_r);
    acc_en_c      = prod_valid && ((state == S_ACCUM) || (state == S_DRAIN))
                    && (snap_cnt_r < nsnap_r);
  end

`ifdef IQ_SNAP_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt, wd_nx;

  always_comb begin
    wd_nx   = '0;
    wd_fire = 1'b0;
    if (((state == S_ACCUM) || (state == S_DRAIN)) && !admit && !acc_en_c) begin
      if (wd_cnt == WD_W'(TIMEOUT_CYC - 1)) wd_fire = 1'b1;
      else                                  wd_nx   = wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wd_cnt <= '0;
    else          wd_cnt <= wd_nx;
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC == 0);
  assign wd_fire    = 1'b0;
`endif

  // NOTE: every variable assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    nsnap_nx    = nsnap_r;
    in_cnt_nx   = in_cnt;
    snap_cnt_nx = snap_cnt_r;
    align_nx    = align_r;
    tmo_nx      = tmo_r;

    if (admit)    in_cnt_nx   = in_cnt + CNT_W'(1);
    if (acc_en_c) snap_cnt_nx = snap_cnt_r + CNT_W'(1);

    unique case (state)
      S_IDLE: begin
        if (start) begin
          nsnap_nx    = num_snap;
          in_cnt_nx   = '0;
          snap_cnt_nx = '0;
          align_nx    = 1'b0;
          tmo_nx      = 1'b0;
          state_nx    = S_CLR;
        end
      end
      S_CLR:   state_nx = (nsnap_r == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: begin
        if (partial_valid)                     align_nx = 1'b1;
        if (admit && (in_cnt_nx == nsnap_r))   state_nx = S_DRAIN;
      end
      // Post-increment compare: the product accepted this cycle can finish the capture.
      S_DRAIN: if (snap_cnt_nx == nsnap_r) state_nx = S_DONE;
      S_DONE:  if (ack) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (wd_fire) begin
      tmo_nx   = 1'b1;
      state_nx = S_DONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      nsnap_r    <= '0;
      in_cnt     <= '0;
      snap_cnt_r <= '0;
      align_r    <= 1'b0;
      tmo_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state      <= state_nx;
      nsnap_r    <= nsnap_nx;
      in_cnt     <= in_cnt_nx;
      snap_cnt_r <= snap_cnt_nx;
      align_r    <= align_nx;
      tmo_r      <= tmo_nx;
      busy_r     <= (state_nx != S_IDLE);
    end
  end

  assign ch_ready  = {8{admit}};
  assign acc_clr   = (state == S_CLR);
  assign acc_en    = acc_en_c;
  assign busy      = busy_r;
  assign done      = (state == S_DONE);
  assign snap_cnt  = snap_cnt_r;
  assign align_err = align_r;
  assign timeout   = tmo_r;

endmodule
